reorder_buffer: RTL and testbench

//  In-order retirement buffer, directly downstream of the MEM/WB pipeline register.

---
 rtl/reorder_buffer_pkg.sv | 35 +++
 rtl/reorder_buffer_if.sv | 50 +++++
 rtl/reorder_buffer.sv | 149 ++++++++++++++
 tb/tb_reorder_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and default sizes for the reorder buffer and its interface.
// Instruction classes and exception causes use the encodings decode and MEM/WB already drive.
package rob_pkg;

  localparam int DEF_ROB_ENTRIES = 16;
  localparam int DEF_IDX_W       = 4;
  localparam int DEF_DATA_W      = 32;

  typedef enum logic [2:0] {
    INSTR_ALU    = 3'd0,
    INSTR_LOAD   = 3'd1,
    INSTR_STORE  = 3'd2,
    INSTR_BRANCH = 3'd3,
    INSTR_MUL    = 3'd4
  } instr_type_t;

  typedef enum logic [2:0] {
    EXC_NONE      = 3'd0,
    EXC_ILLEGAL   = 3'd1,
    EXC_MISALIGN  = 3'd2,
    EXC_PAGEFAULT = 3'd3
  } exc_code_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [4:0]            rd;
    logic                  we;
    logic [2:0]            itype;
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_DATA_W-1:0] value;
    logic [2:0]            exc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Signal bundle between decode, MEM/WB, the commit consumers and the reorder buffer.
// The master modport is the pipeline side; the slave modport is the buffer itself.
interface reorder_buffer_if
  import rob_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_flush;
  logic              in_alloc_valid;
  logic [4:0]        in_alloc_rd;
  logic              in_alloc_write_enable;
  logic [2:0]        in_alloc_instr_type;
  logic [DATA_W-1:0] in_alloc_pc;
  logic [IDX_W-1:0]  out_alloc_idx;
  logic              out_full;
  logic              in_complete;
  logic [IDX_W-1:0]  in_complete_idx;
  logic [DATA_W-1:0] in_complete_value;
  logic [2:0]        in_exception_vector;
  logic              out_commit_valid;
  logic [4:0]        out_commit_rd;
  logic [DATA_W-1:0] out_commit_value;
  logic              out_commit_write_enable;
  logic [2:0]        out_commit_instr_type;
  logic              out_exception;
  logic [2:0]        out_exception_vector;
  logic [DATA_W-1:0] out_exception_pc;
  logic              out_empty;

  modport master (
    output in_flush, in_alloc_valid, in_alloc_rd, in_alloc_write_enable,
    output in_alloc_instr_type, in_alloc_pc,
    output in_complete, in_complete_idx, in_complete_value, in_exception_vector,
    input  out_alloc_idx, out_full, out_empty,
    input  out_commit_valid, out_commit_rd, out_commit_value, out_commit_write_enable,
    input  out_commit_instr_type, out_exception, out_exception_vector, out_exception_pc
  );

  modport slave (
    input  in_flush, in_alloc_valid, in_alloc_rd, in_alloc_write_enable,
    input  in_alloc_instr_type, in_alloc_pc,
    input  in_complete, in_complete_idx, in_complete_value, in_exception_vector,
    output out_alloc_idx, out_full, out_empty,
    output out_commit_valid, out_commit_rd, out_commit_value, out_commit_write_enable,
    output out_commit_instr_type, out_exception, out_exception_vector, out_exception_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates in program order, takes completions by index in any
// order, and retires the head one instruction per cycle; a faulting head empties the buffer.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_ENTRIES = DEF_ROB_ENTRIES,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave rob
);

  localparam int CNT_W = IDX_W + 1;

  logic [ROB_ENTRIES-1:0] valid;
  logic [ROB_ENTRIES-1:0] done;
  logic [4:0]             entry_rd    [ROB_ENTRIES];
  logic                   entry_we    [ROB_ENTRIES];
  logic [2:0]             entry_type  [ROB_ENTRIES];
  logic [DATA_W-1:0]      entry_pc    [ROB_ENTRIES];
  logic [DATA_W-1:0]      entry_value [ROB_ENTRIES];
  logic [2:0]             entry_exc   [ROB_ENTRIES];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic full;
  logic alloc_fire;
  logic head_ready;
  logic head_exc;
  logic complete_hit;
  logic wipe;

  // Full is judged on the registered count, so a commit in the same cycle never frees a slot early.
  assign full         = (count == CNT_W'(ROB_ENTRIES));
  assign alloc_fire   = rob.in_alloc_valid && !full;
  assign head_ready   = valid[head] && done[head];
  assign head_exc     = head_ready && (entry_exc[head] != EXC_NONE);
  assign complete_hit = rob.in_complete && valid[rob.in_complete_idx];
  assign wipe         = rob.in_flush || head_exc;

  assign rob.out_alloc_idx = tail;
  assign rob.out_full      = full;
  assign rob.out_empty     = (count == {CNT_W{1'b0}});

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || wipe) begin
      head  <= {IDX_W{1'b0}};
      tail  <= {IDX_W{1'b0}};
      count <= {CNT_W{1'b0}};
    end else begin
      if (alloc_fire) begin
        tail <= tail + IDX_W'(1);
      end
      if (head_ready) begin
        head <= head + IDX_W'(1);
      end
      case ({alloc_fire, head_ready})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry valid/done flags; retiring the head outranks a late completion to it.
  always_ff @(posedge clk) begin
    if (reset || wipe) begin
      valid <= {ROB_ENTRIES{1'b0}};
      done  <= {ROB_ENTRIES{1'b0}};
    end else begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        if (head_ready && (head == IDX_W'(i))) begin
          valid[i] <= 1'b0;
          done[i]  <= 1'b0;
        end else if (alloc_fire && (tail == IDX_W'(i))) begin
          valid[i] <= 1'b1;
          done[i]  <= 1'b0;
        end else if (complete_hit && (rob.in_complete_idx == IDX_W'(i))) begin
          done[i] <= 1'b1;
        end
      end
    end
  end

  // Entry payload: decode fields at allocation, result and cause at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        entry_rd[i]    <= 5'd0;
        entry_we[i]    <= 1'b0;
        entry_type[i]  <= 3'd0;
        entry_pc[i]    <= {DATA_W{1'b0}};
        entry_value[i] <= {DATA_W{1'b0}};
        entry_exc[i]   <= EXC_NONE;
      end
    end else begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        if (alloc_fire && (tail == IDX_W'(i))) begin
          entry_rd[i]    <= rob.in_alloc_rd;
          entry_we[i]    <= rob.in_alloc_write_enable;
          entry_type[i]  <= rob.in_alloc_instr_type;
          entry_pc[i]    <= rob.in_alloc_pc;
          entry_value[i] <= {DATA_W{1'b0}};
          entry_exc[i]   <= EXC_NONE;
        end else if (complete_hit && (rob.in_complete_idx == IDX_W'(i))) begin
          entry_value[i] <= rob.in_complete_value;
          entry_exc[i]   <= rob.in_exception_vector;
        end
      end
    end
  end

  // Commit and exception outputs; the cause and PC survive a flush until the next fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      rob.out_commit_valid        <= 1'b0;
      rob.out_commit_rd           <= 5'd0;
      rob.out_commit_value        <= {DATA_W{1'b0}};
      rob.out_commit_write_enable <= 1'b0;
      rob.out_commit_instr_type   <= 3'd0;
      rob.out_exception           <= 1'b0;
      rob.out_exception_vector    <= 3'd0;
      rob.out_exception_pc        <= {DATA_W{1'b0}};
    end else if (rob.in_flush) begin
      rob.out_commit_valid <= 1'b0;
      rob.out_exception    <= 1'b0;
    end else if (head_ready) begin
      rob.out_commit_valid        <= 1'b1;
      rob.out_commit_rd           <= entry_rd[head];
      rob.out_commit_value        <= entry_value[head];
      rob.out_commit_write_enable <= entry_we[head] && !head_exc;
      rob.out_commit_instr_type   <= entry_type[head];
      rob.out_exception           <= head_exc;
      if (head_exc) begin
        rob.out_exception_vector <= entry_exc[head];
        rob.out_exception_pc     <= entry_pc[head];
      end
    end else begin
      rob.out_commit_valid <= 1'b0;
      rob.out_exception    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scenario bench for reorder_buffer: a program-order queue of allocated indices is the
// scoreboard; every observed commit is popped and checked against the bench's own entry model.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if #(.IDX_W(4), .DATA_W(32)) rif ();

  reorder_buffer #(.ROB_ENTRIES(16), .IDX_W(4), .DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .rob  (rif)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int commits_seen = 0;

  int          order_q[$];
  logic        m_valid[16];
  logic        m_done[16];
  int          m_done_cyc[16];
  logic [4:0]  m_rd[16];
  logic        m_we[16];
  logic [2:0]  m_type[16];
  logic [31:0] m_pc[16];
  logic [31:0] m_value[16];
  logic [2:0]  m_exc[16];
  int          m_tail = 0;
  int          m_count = 0;

  function automatic void model_clear();
    order_q.delete();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
    m_tail  = 0;
    m_count = 0;
  endfunction

  // One clock: model the edge from the driven inputs, then score any commit at the negedge.
  task automatic step();
    int h;
    @(posedge clk);
    cyc++;
    if (reset || rif.in_flush) begin
      model_clear();
    end else begin
      if (rif.in_complete && m_valid[rif.in_complete_idx]) begin
        m_done[rif.in_complete_idx]     = 1'b1;
        m_done_cyc[rif.in_complete_idx] = cyc;
        m_value[rif.in_complete_idx]    = rif.in_complete_value;
        m_exc[rif.in_complete_idx]      = rif.in_exception_vector;
      end
      if (rif.in_alloc_valid && m_count < 16) begin
        m_valid[m_tail] = 1'b1;
        m_done[m_tail]  = 1'b0;
        m_rd[m_tail]    = rif.in_alloc_rd;
        m_we[m_tail]    = rif.in_alloc_write_enable;
        m_type[m_tail]  = rif.in_alloc_instr_type;
        m_pc[m_tail]    = rif.in_alloc_pc;
        m_value[m_tail] = 32'd0;
        m_exc[m_tail]   = 3'd0;
        order_q.push_back(m_tail);
        m_tail  = (m_tail + 1) % 16;
        m_count = m_count + 1;
      end
    end
    @(negedge clk);
    if (rif.out_commit_valid === 1'b1) begin
      checks++;
      if (order_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected got rd=%0d value=%h required no commit", rif.out_commit_rd, rif.out_commit_value);
      end else begin
        h = order_q.pop_front();
        m_valid[h] = 1'b0;
        m_count = m_count - 1;
        commits_seen++;
        checks++;
        if (!(m_done[h] && m_done_cyc[h] < cyc)) begin
          errors++;
          $display("FAIL commit_early idx=%0d done=%0b done_cyc=%0d cyc=%0d", h, m_done[h], m_done_cyc[h], cyc);
        end
        checks++;
        if (rif.out_commit_rd !== m_rd[h]) begin
          errors++;
          $display("FAIL commit_rd idx=%0d got %0d required %0d", h, rif.out_commit_rd, m_rd[h]);
        end
        checks++;
        if (rif.out_commit_value !== m_value[h]) begin
          errors++;
          $display("FAIL commit_value idx=%0d got %h required %h", h, rif.out_commit_value, m_value[h]);
        end
        checks++;
        if (rif.out_commit_instr_type !== m_type[h]) begin
          errors++;
          $display("FAIL commit_type idx=%0d got %0d required %0d", h, rif.out_commit_instr_type, m_type[h]);
        end
        checks++;
        if (rif.out_commit_write_enable !== (m_we[h] && m_exc[h] == 3'd0)) begin
          errors++;
          $display("FAIL commit_we idx=%0d got %0b required %0b", h, rif.out_commit_write_enable, (m_we[h] && m_exc[h] == 3'd0));
        end
        checks++;
        if (rif.out_exception !== (m_exc[h] != 3'd0)) begin
          errors++;
          $display("FAIL commit_exception idx=%0d got %0b required %0b", h, rif.out_exception, (m_exc[h] != 3'd0));
        end
        if (m_exc[h] != 3'd0) begin
          checks++;
          if (rif.out_exception_vector !== m_exc[h] || rif.out_exception_pc !== m_pc[h]) begin
            errors++;
            $display("FAIL exception_info got vec=%0d pc=%h required vec=%0d pc=%h", rif.out_exception_vector, rif.out_exception_pc, m_exc[h], m_pc[h]);
          end
          model_clear();
        end
      end
    end else begin
      checks++;
      if (rif.out_exception !== 1'b0) begin
        errors++;
        $display("FAIL exception_without_commit got %0b required 0", rif.out_exception);
      end
    end
    rif.in_alloc_valid = 1'b0;
    rif.in_complete    = 1'b0;
    rif.in_flush       = 1'b0;
  endtask

  task automatic set_alloc(input logic [4:0] rd, input logic we, input instr_type_t typ, input logic [31:0] pc);
    rif.in_alloc_valid        = 1'b1;
    rif.in_alloc_rd           = rd;
    rif.in_alloc_write_enable = we;
    rif.in_alloc_instr_type   = typ;
    rif.in_alloc_pc           = pc;
  endtask

  task automatic set_complete(input int idx, input logic [31:0] value, input logic [2:0] exc);
    rif.in_complete         = 1'b1;
    rif.in_complete_idx     = 4'(idx);
    rif.in_complete_value   = value;
    rif.in_exception_vector = exc;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (rif.out_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b required 1", rif.out_empty); end
    checks++; if (rif.out_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b required 0", rif.out_full); end
    checks++; if (rif.out_alloc_idx !== 4'd0) begin errors++; $display("FAIL reset_alloc_idx got %0d required 0", rif.out_alloc_idx); end
    checks++; if (rif.out_commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %0b required 0", rif.out_commit_valid); end
    checks++; if (rif.out_exception_vector !== 3'd0 || rif.out_exception_pc !== 32'd0) begin errors++; $display("FAIL reset_exc_info got %0d/%h required 0/0", rif.out_exception_vector, rif.out_exception_pc); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_in_order();
    int base;
    pulse_reset();
    base = commits_seen;
    for (int i = 0; i < 3; i++) begin
      set_alloc(5'(i + 1), 1'b1, INSTR_ALU, 32'h100 + 32'(4 * i));
      checks++; if (rif.out_alloc_idx !== 4'(i)) begin errors++; $display("FAIL inorder_alloc_idx got %0d required %0d", rif.out_alloc_idx, i); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_complete(i, 32'hA + 32'(i), EXC_NONE);
      step();
    end
    for (int k = 0; k < 10 && order_q.size() != 0; k++) step();
    checks++; if (commits_seen - base != 3) begin errors++; $display("FAIL inorder_commit_count got %0d required 3", commits_seen - base); end
    checks++; if (rif.out_empty !== 1'b1) begin errors++; $display("FAIL inorder_empty got %0b required 1", rif.out_empty); end
  endtask

  task automatic test_out_of_order();
    int base;
    instr_type_t types[4] = '{INSTR_ALU, INSTR_LOAD, INSTR_STORE, INSTR_BRANCH};
    pulse_reset();
    base = commits_seen;
    for (int i = 0; i < 4; i++) begin
      set_alloc(5'(10 + i), (i != 2), types[i], 32'h200 + 32'(4 * i));
      checks++; if (rif.out_alloc_idx !== 4'(i)) begin errors++; $display("FAIL ooo_alloc_idx got %0d required %0d", rif.out_alloc_idx, i); end
      step();
    end
    for (int i = 3; i >= 1; i--) begin
      set_complete(i, 32'h300 + 32'(i), EXC_NONE);
      step();
    end
    step();
    step();
    checks++; if (commits_seen != base) begin errors++; $display("FAIL ooo_no_commit got %0d commits required 0", commits_seen - base); end
    set_complete(0, 32'h300, EXC_NONE);
    step();
    checks++; if (rif.out_commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_latency got commit_valid %0b required 0", rif.out_commit_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (rif.out_commit_valid !== 1'b1) begin errors++; $display("FAIL ooo_consecutive cycle %0d got %0b required 1", k, rif.out_commit_valid); end
    end
    step();
    checks++; if (rif.out_commit_valid !== 1'b0 || rif.out_empty !== 1'b1) begin errors++; $display("FAIL ooo_after got valid %0b empty %0b required 0/1", rif.out_commit_valid, rif.out_empty); end
  endtask

  task automatic test_fill_wrap();
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(5'(i + 1), 1'b1, INSTR_MUL, 32'h400 + 32'(4 * i));
      checks++; if (rif.out_alloc_idx !== 4'(i)) begin errors++; $display("FAIL fill_alloc_idx got %0d required %0d", rif.out_alloc_idx, i); end
      step();
    end
    checks++; if (rif.out_full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b required 1", rif.out_full); end
    set_alloc(5'd30, 1'b1, INSTR_ALU, 32'hBAD0);
    step();
    checks++; if (rif.out_alloc_idx !== 4'd0 || rif.out_full !== 1'b1) begin errors++; $display("FAIL fill_17th got idx %0d full %0b required 0/1", rif.out_alloc_idx, rif.out_full); end
    set_complete(0, 32'h500, EXC_NONE);
    step();
    set_alloc(5'd20, 1'b1, INSTR_ALU, 32'hBAD4);
    step();
    checks++; if (rif.out_commit_valid !== 1'b1 || rif.out_full !== 1'b0 || rif.out_alloc_idx !== 4'd0) begin errors++; $display("FAIL fill_commit_unblock got valid %0b full %0b idx %0d required 1/0/0", rif.out_commit_valid, rif.out_full, rif.out_alloc_idx); end
    set_alloc(5'd21, 1'b1, INSTR_STORE, 32'h600);
    step();
    checks++; if (rif.out_alloc_idx !== 4'd1 || rif.out_full !== 1'b1) begin errors++; $display("FAIL fill_wrap_alloc got idx %0d full %0b required 1/1", rif.out_alloc_idx, rif.out_full); end
    for (int k = 1; k <= 16; k++) begin
      set_complete(k % 16, 32'h500 + 32'(k), EXC_NONE);
      step();
    end
    for (int k = 0; k < 10 && order_q.size() != 0; k++) step();
    checks++; if (order_q.size() != 0 || rif.out_empty !== 1'b1) begin errors++; $display("FAIL fill_drain got pending %0d empty %0b required 0/1", order_q.size(), rif.out_empty); end
  endtask

  task automatic test_exception();
    pulse_reset();
    set_alloc(5'd5, 1'b1, INSTR_ALU, 32'h3C);  step();
    set_alloc(5'd6, 1'b1, INSTR_LOAD, 32'h40); step();
    set_alloc(5'd7, 1'b1, INSTR_ALU, 32'h44);  step();
    set_complete(1, 32'hDEAD, EXC_MISALIGN); step();
    set_complete(2, 32'h22, EXC_NONE);       step();
    set_complete(0, 32'h11, EXC_NONE);       step();
    step();
    checks++; if (rif.out_commit_valid !== 1'b1 || rif.out_exception !== 1'b0 || rif.out_commit_write_enable !== 1'b1) begin errors++; $display("FAIL exc_idx0 got valid %0b exc %0b we %0b required 1/0/1", rif.out_commit_valid, rif.out_exception, rif.out_commit_write_enable); end
    set_alloc(5'd9, 1'b1, INSTR_ALU, 32'h48);
    step();
    checks++; if (rif.out_exception !== 1'b1 || rif.out_exception_vector !== 3'd2 || rif.out_exception_pc !== 32'h40 || rif.out_commit_write_enable !== 1'b0) begin errors++; $display("FAIL exc_pulse got exc %0b vec %0d pc %h we %0b required 1/2/40/0", rif.out_exception, rif.out_exception_vector, rif.out_exception_pc, rif.out_commit_write_enable); end
    checks++; if (rif.out_empty !== 1'b1 || rif.out_alloc_idx !== 4'd0) begin errors++; $display("FAIL exc_wipe got empty %0b idx %0d required 1/0", rif.out_empty, rif.out_alloc_idx); end
    step();
    checks++; if (rif.out_exception !== 1'b0 || rif.out_exception_vector !== 3'd2 || rif.out_exception_pc !== 32'h40 || rif.out_empty !== 1'b1) begin errors++; $display("FAIL exc_hold got exc %0b vec %0d pc %h empty %0b required 0/2/40/1", rif.out_exception, rif.out_exception_vector, rif.out_exception_pc, rif.out_empty); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_alloc(5'(i + 1), 1'b1, INSTR_ALU, 32'h700 + 32'(4 * i));
      checks++; if (rif.out_alloc_idx !== 4'(i)) begin errors++; $display("FAIL flush_alloc_idx got %0d required %0d", rif.out_alloc_idx, i); end
      step();
    end
    set_complete(0, 32'h77, EXC_NONE);
    step();
    rif.in_flush = 1'b1;
    step();
    checks++; if (rif.out_commit_valid !== 1'b0 || rif.out_empty !== 1'b1 || rif.out_alloc_idx !== 4'd0) begin errors++; $display("FAIL flush_state got valid %0b empty %0b idx %0d required 0/1/0", rif.out_commit_valid, rif.out_empty, rif.out_alloc_idx); end
    checks++; if (rif.out_exception_vector !== 3'd2 || rif.out_exception_pc !== 32'h40) begin errors++; $display("FAIL flush_keeps_exc got vec %0d pc %h required 2/40", rif.out_exception_vector, rif.out_exception_pc); end
    set_complete(1, 32'hBAD, EXC_NONE);
    step();
    set_alloc(5'd11, 1'b1, INSTR_ALU, 32'h800); step();
    set_alloc(5'd12, 1'b1, INSTR_ALU, 32'h804); step();
    set_complete(0, 32'h88, EXC_NONE); step();
    step();
    step();
    step();
    checks++; if (order_q.size() != 1 || rif.out_empty !== 1'b0) begin errors++; $display("FAIL flush_stale_complete got pending %0d empty %0b required 1/0", order_q.size(), rif.out_empty); end
    set_complete(1, 32'h99, EXC_NONE);
    step();
    for (int k = 0; k < 10 && order_q.size() != 0; k++) step();
    checks++; if (order_q.size() != 0 || rif.out_empty !== 1'b1) begin errors++; $display("FAIL flush_drain got pending %0d empty %0b required 0/1", order_q.size(), rif.out_empty); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = m_tail;
    for (int i = 0; i < 8; i++) begin
      set_alloc(5'(i + 1), 1'b1, INSTR_LOAD, 32'h900 + 32'(4 * i));
      checks++; if (rif.out_alloc_idx !== 4'((base + i) % 16)) begin errors++; $display("FAIL rmid_alloc_idx got %0d required %0d", rif.out_alloc_idx, (base + i) % 16); end
      step();
    end
    for (int i = 4; i < 8; i++) begin
      set_complete((base + i) % 16, 32'hA00 + 32'(i), EXC_NONE);
      step();
    end
    reset = 1'b1;
    step();
    checks++; if (rif.out_commit_valid !== 1'b0 || rif.out_commit_rd !== 5'd0 || rif.out_commit_value !== 32'd0 || rif.out_commit_write_enable !== 1'b0 || rif.out_commit_instr_type !== 3'd0) begin errors++; $display("FAIL rmid_commit_outs got %0b/%0d/%h/%0b/%0d required all 0", rif.out_commit_valid, rif.out_commit_rd, rif.out_commit_value, rif.out_commit_write_enable, rif.out_commit_instr_type); end
    checks++; if (rif.out_exception !== 1'b0 || rif.out_exception_vector !== 3'd0 || rif.out_exception_pc !== 32'd0) begin errors++; $display("FAIL rmid_exc_outs got %0b/%0d/%h required 0/0/0", rif.out_exception, rif.out_exception_vector, rif.out_exception_pc); end
    checks++; if (rif.out_empty !== 1'b1 || rif.out_full !== 1'b0 || rif.out_alloc_idx !== 4'd0) begin errors++; $display("FAIL rmid_status got empty %0b full %0b idx %0d required 1/0/0", rif.out_empty, rif.out_full, rif.out_alloc_idx); end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (rif.out_commit_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_commit cycle %0d got %0b required 0", k, rif.out_commit_valid); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rif.in_flush = 1'b0;
    rif.in_alloc_valid = 1'b0;
    rif.in_alloc_rd = 5'd0;
    rif.in_alloc_write_enable = 1'b0;
    rif.in_alloc_instr_type = 3'd0;
    rif.in_alloc_pc = 32'd0;
    rif.in_complete = 1'b0;
    rif.in_complete_idx = 4'd0;
    rif.in_complete_value = 32'd0;
    rif.in_exception_vector = 3'd0;
    model_clear();
    test_reset();
    test_in_order();
    test_out_of_order();
    test_fill_wrap();
    test_exception();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
